// File: rtl/spi_master_if.sv
// Bus between the SPI master and its local controller/slave: handshake, data words and SPI pins.
// The master modport is the DUT side; the slave modport is the controller/slave side.
interface spi_master_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] rx_data;
   logic              busy;
   logic              done;
   logic              sclk;
   logic              cs_n;
   logic              mosi;
   logic              miso;

   modport master (
      input  start, tx_data, miso,
      output rx_data, busy, done, sclk, cs_n, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  rx_data, busy, done, sclk, cs_n, mosi
   );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master, one DATA_W-bit frame per start, with start/busy/done handshake.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | cs_n high, waiting for start
// S_SETUP | cs_n low, first bit on mosi, sclk low for CLK_DIV cycles
// S_XFER  | sclk toggling, sample miso on rise, advance mosi on fall
// S_HOLD  | sclk low, cs_n still low for CLK_DIV cycles after last fall
// S_GAP   | cs_n high, busy still high for CLK_DIV cycles
module spi_master #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8
) (
   input logic          clk,
   input logic          rst_n,
   spi_master_if.master bus
);
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   localparam logic [CW-1:0] DIV_FULL = CW'(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   logic [2:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic [BW-1:0]     r_bit;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_sclk;
   logic              r_cs_n;
   logic              r_mosi;
   logic              r_busy;
   logic              r_done;

   logic              w_tick;
   logic              w_first;
   logic              w_next;
   logic [DATA_W-1:0] w_shift_nx;
   logic [DATA_W-1:0] w_rx_nx;

   assign w_tick = (r_cnt == '0);

`ifdef SPI_MASTER_LSB_FIRST_EN
   assign w_first    = r_shift[0];
   assign w_next     = r_shift[1];
   assign w_shift_nx = {1'b0, r_shift[DATA_W-1:1]};
   assign w_rx_nx    = {bus.miso, r_rx[DATA_W-1:1]};
`else
   assign w_first    = r_shift[DATA_W-1];
   assign w_next     = r_shift[DATA_W-2];
   assign w_shift_nx = {r_shift[DATA_W-2:0], 1'b0};
   assign w_rx_nx    = {r_rx[DATA_W-2:0], bus.miso};
`endif

   // Half-period counter is reloaded with CLK_DIV on accept so that SETUP
   // spans the accept-to-cs_n latency plus a full half-period of mosi setup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_rx      <= '0;
         r_rx_data <= '0;
         r_sclk    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cs_n <= 1'b1;
               r_sclk <= 1'b0;
               r_mosi <= 1'b0;
               r_busy <= 1'b0;
               if (bus.start) begin
                  r_shift <= bus.tx_data;
                  r_bit   <= '0;
                  r_cnt   <= DIV_FULL;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_cs_n <= 1'b0;
               r_busy <= 1'b1;
               r_mosi <= w_first;
               if (w_tick) begin
                  r_sclk  <= 1'b1;
                  r_rx    <= w_rx_nx;
                  r_cnt   <= DIV_LAST;
                  r_state <= S_XFER;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_XFER: begin
               if (w_tick) begin
                  r_cnt <= DIV_LAST;
                  if (r_sclk) begin
                     r_sclk <= 1'b0;
                     if (r_bit == BIT_LAST) begin
                        r_state <= S_HOLD;
                     end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_mosi  <= w_next;
                        r_shift <= w_shift_nx;
                     end
                  end else begin
                     r_sclk <= 1'b1;
                     r_rx   <= w_rx_nx;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (w_tick) begin
                  r_cs_n    <= 1'b1;
                  r_mosi    <= 1'b0;
                  r_rx_data <= r_rx;
                  r_done    <= 1'b1;
                  r_cnt     <= DIV_LAST;
                  r_state   <= S_GAP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (w_tick) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.rx_data = r_rx_data;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.sclk    = r_sclk;
   assign bus.cs_n    = r_cs_n;
   assign bus.mosi    = r_mosi;
endmodule
